// File: rtl/commit_trace_buffer_if.sv
// Bus bundle between the commit trace buffer and its neighbours: the
// retired-instruction input stream, the valid/ready drain port towards the
// trace host, and the status counters and flags.
interface commit_trace_buffer_if #(
    parameter int DEPTH = 8
);
    logic                     commit;
    logic [31:0]              commit_instr;
    logic [63:0]              commit_pc;
    logic [63:0]              commit_pre_pc;

    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_instr;
    logic [63:0]              out_pc;
    logic [63:0]              out_pre_pc;
    logic [31:0]              out_seq;

    logic [63:0]              retire_cnt;
    logic [15:0]              drop_cnt;
    logic                     overflow;
    logic                     hang;
    logic [$clog2(DEPTH):0]   level;

    // Driver side: the CPU commit port plus the host's ready.
    modport master (
        output commit, commit_instr, commit_pc, commit_pre_pc, out_ready,
        input  out_valid, out_instr, out_pc, out_pre_pc, out_seq,
        input  retire_cnt, drop_cnt, overflow, hang, level
    );

    // Buffer side.
    modport slave (
        input  commit, commit_instr, commit_pc, commit_pre_pc, out_ready,
        output out_valid, out_instr, out_pc, out_pre_pc, out_seq,
        output retire_cnt, drop_cnt, overflow, hang, level
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures every retired instruction record into a small
// register FIFO, drains it to the trace host over valid/ready, and keeps a
// retire counter, per-commit sequence numbers, drop accounting and a
// no-commit watchdog. The commit stream is never stalled.
module commit_trace_buffer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input logic                    clk,
    input logic                    rst,
    commit_trace_buffer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LEVEL  = CW'(DEPTH);
    localparam logic [31:0]   HANG_LIMIT  = 32'(TIMEOUT);
    localparam logic [31:0]   HANG_ARMED  = 32'(TIMEOUT - 1);

    logic [31:0] memInstr [DEPTH];
    logic [63:0] memPc    [DEPTH];
    logic [63:0] memPrePc [DEPTH];
    logic [31:0] memSeq   [DEPTH];

    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [CW-1:0] count;

    logic [31:0] seq;
    logic [31:0] idleCnt;
    logic [63:0] retireCnt;
    logic [15:0] dropCnt;
    logic        overflowFlag;
    logic        hangFlag;

    logic pop;
    logic push;
    logic drop;

    // A full FIFO still accepts a commit when the head leaves in the same cycle.
    assign pop  = (count != '0) && bus.out_ready;
    assign push = bus.commit && ((count != FULL_LEVEL) || pop);
    assign drop = bus.commit && (count == FULL_LEVEL) && !pop;

    // FIFO storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                memInstr[i] <= '0;
                memPc[i]    <= '0;
                memPrePc[i] <= '0;
                memSeq[i]   <= '0;
            end
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                memInstr[wrPtr] <= bus.commit_instr;
                memPc[wrPtr]    <= bus.commit_pc;
                memPrePc[wrPtr] <= bus.commit_pre_pc;
                memSeq[wrPtr]   <= seq;
                wrPtr           <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequence, retire and drop accounting; seq advances even for dropped
    // commits so the host can see the gaps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq          <= '0;
            retireCnt    <= '0;
            dropCnt      <= '0;
            overflowFlag <= 1'b0;
        end else begin
            if (bus.commit) begin
                seq       <= seq + 32'd1;
                retireCnt <= retireCnt + 64'd1;
            end
            if (drop) begin
                overflowFlag <= 1'b1;
                if (dropCnt != 16'hFFFF) begin
                    dropCnt <= dropCnt + 16'd1;
                end
            end
        end
    end

    // Watchdog: hang latches on the edge where the idle count reaches the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idleCnt  <= '0;
            hangFlag <= 1'b0;
        end else begin
            if (bus.commit) begin
                idleCnt <= '0;
            end else begin
                if (idleCnt != HANG_LIMIT) begin
                    idleCnt <= idleCnt + 32'd1;
                end
                if (idleCnt >= HANG_ARMED) begin
                    hangFlag <= 1'b1;
                end
            end
        end
    end

    assign bus.out_valid  = (count != '0);
    assign bus.out_instr  = memInstr[rdPtr];
    assign bus.out_pc     = memPc[rdPtr];
    assign bus.out_pre_pc = memPrePc[rdPtr];
    assign bus.out_seq    = memSeq[rdPtr];
    assign bus.retire_cnt = retireCnt;
    assign bus.drop_cnt   = dropCnt;
    assign bus.overflow   = overflowFlag;
    assign bus.hang       = hangFlag;
    assign bus.level      = count;
endmodule
